// File: rtl/banked_reservation_station_pkg.sv
// Shared types and sizes for the banked reservation station.
// Also holds the age comparison used by the per-bank oldest-entry select.
package banked_reservation_station_pkg;

  localparam int PHY_REG_NUM = 64;
  localparam int ROB_DEPTH   = 64;
  localparam int PREG_W      = $clog2(PHY_REG_NUM);
  localparam int ROB_W       = $clog2(ROB_DEPTH);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [ROB_W-1:0]  rob_idx_t;

  // FU-specific option code; the station carries it without looking inside
  typedef struct packed {
    logic [3:0] fu_op;
    logic       sign;
    logic [2:0] width;
  } OptionCodeSt;

  typedef struct packed {
    preg_t       psrc0;
    logic        psrc0_valid;
    logic        psrc0_ready;
    preg_t       psrc1;
    logic        psrc1_valid;
    logic        psrc1_ready;
    preg_t       pdest;
    logic [15:0] imm;
    rob_idx_t    rob_idx;
    logic        position_bit;
  } RsBaseSt;

  typedef struct packed {
    preg_t       psrc0;
    preg_t       psrc1;
    preg_t       pdest;
    logic [15:0] imm;
    rob_idx_t    rob_idx;
  } IssueBaseSt;

  // position_bit flips each time rob_idx wraps, so differing bits invert the order
  function automatic logic age_older(input logic pb_a, input rob_idx_t idx_a,
                                     input logic pb_b, input rob_idx_t idx_b);
    return (pb_a == pb_b) ? (idx_a < idx_b) : (idx_a > idx_b);
  endfunction

endpackage

// File: rtl/banked_reservation_station_if.sv
// Dispatch, wakeup and issue bus of the banked reservation station.
// slave = the station, master = dispatch/writeback/FU side.
interface banked_reservation_station_if #(
  parameter int BANK_NUM     = 2,
  parameter int BANK_SIZE    = 4,
  parameter int WAKEUP_WIDTH = 4
);
  import banked_reservation_station_pkg::*;

  localparam int OCC_W = $clog2(BANK_SIZE + 1);

  RsBaseSt     [BANK_NUM-1:0]     rs_base_i;
  OptionCodeSt [BANK_NUM-1:0]     option_code_i;
  logic        [BANK_NUM-1:0]     wr_valid_i;
  logic        [BANK_NUM-1:0]     wr_ready_o;
  logic        [WAKEUP_WIDTH-1:0] wakeup_valid_i;
  preg_t       [WAKEUP_WIDTH-1:0] wakeup_pdest_i;
  logic        [BANK_NUM-1:0]     issue_ready_i;
  logic        [BANK_NUM-1:0]     issue_valid_o;
  IssueBaseSt  [BANK_NUM-1:0]     issue_base_o;
  OptionCodeSt [BANK_NUM-1:0]     issue_oc_o;
  logic        [BANK_NUM-1:0][OCC_W-1:0] occupancy_o;

  modport slave (
    input  rs_base_i, option_code_i, wr_valid_i, wakeup_valid_i, wakeup_pdest_i, issue_ready_i,
    output wr_ready_o, issue_valid_o, issue_base_o, issue_oc_o, occupancy_o
  );

  modport master (
    output rs_base_i, option_code_i, wr_valid_i, wakeup_valid_i, wakeup_pdest_i, issue_ready_i,
    input  wr_ready_o, issue_valid_o, issue_base_o, issue_oc_o, occupancy_o
  );

endinterface

// File: rtl/banked_reservation_station_select.sv
// rs_oldest_select: picks the oldest requesting entry of one bank.
// Equal ages resolve to the lower entry index.
module rs_oldest_select
  import banked_reservation_station_pkg::*;
#(
  parameter int BANK_SIZE = 4
) (
  input  logic     [BANK_SIZE-1:0]         req_i,
  input  logic     [BANK_SIZE-1:0]         pb_i,
  input  rob_idx_t [BANK_SIZE-1:0]         rob_idx_i,
  output logic     [BANK_SIZE-1:0]         gnt_o,
  output logic     [$clog2(BANK_SIZE)-1:0] gnt_idx_o,
  output logic                             gnt_valid_o
);
  localparam int IDX_W = $clog2(BANK_SIZE);

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int e = 0; e < BANK_SIZE; e++) begin
      // strict comparison keeps the earlier (lower) index on a tie
      if (req_i[e] && (!sel_vld ||
          age_older(pb_i[e], rob_idx_i[e], pb_i[sel_idx], rob_idx_i[sel_idx]))) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(e);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (sel_vld) gnt_o[sel_idx] = 1'b1;
  end

  assign gnt_idx_o   = sel_idx;
  assign gnt_valid_o = sel_vld;

endmodule

// File: rtl/banked_reservation_station.sv
// Banked reservation station: wakeup capture and oldest-ready issue per bank.
// RS_WAKEUP_BYPASS_EN: same-cycle wakeups also count toward issuability.
module banked_reservation_station
  import banked_reservation_station_pkg::*;
#(
  parameter int BANK_NUM     = 2,
  parameter int BANK_SIZE    = 4,
  parameter int WAKEUP_WIDTH = 4
) (
  input logic clk,
  input logic a_rst_n,
  input logic flush_i,
  banked_reservation_station_if.slave bus
);
  localparam int IDX_W = $clog2(BANK_SIZE);
  localparam int OCC_W = $clog2(BANK_SIZE + 1);

  logic [BANK_NUM-1:0][BANK_SIZE-1:0] valid_q, valid_d;
  RsBaseSt     base_q [BANK_NUM][BANK_SIZE];
  RsBaseSt     base_d [BANK_NUM][BANK_SIZE];
  OptionCodeSt oc_q   [BANK_NUM][BANK_SIZE];
  OptionCodeSt oc_d   [BANK_NUM][BANK_SIZE];
  logic [BANK_NUM-1:0][OCC_W-1:0] occ_q, occ_d;

  logic     [BANK_NUM-1:0][BANK_SIZE-1:0] req, pb_vec, gnt_oh;
  rob_idx_t [BANK_NUM-1:0][BANK_SIZE-1:0] rob_vec;
  logic     [BANK_NUM-1:0][IDX_W-1:0]     gnt_idx, free_idx;
  logic     [BANK_NUM-1:0]                gnt_vld, free_vld;

  function automatic logic wk_hit(input preg_t p, input logic [WAKEUP_WIDTH-1:0] wv,
                                  input preg_t [WAKEUP_WIDTH-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKEUP_WIDTH; k++)
      hit = hit | (wv[k] & (wp[k] == p));
    return hit & (p != '0);
  endfunction

  function automatic RsBaseSt wk_apply(input RsBaseSt e, input logic [WAKEUP_WIDTH-1:0] wv,
                                       input preg_t [WAKEUP_WIDTH-1:0] wp);
    RsBaseSt r;
    r = e;
    if (e.psrc0_valid && wk_hit(e.psrc0, wv, wp)) r.psrc0_ready = 1'b1;
    if (e.psrc1_valid && wk_hit(e.psrc1, wv, wp)) r.psrc1_ready = 1'b1;
    return r;
  endfunction

  always_comb begin
    req     = '0;
    pb_vec  = '0;
    rob_vec = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int e = 0; e < BANK_SIZE; e++) begin
        pb_vec[b][e]  = base_q[b][e].position_bit;
        rob_vec[b][e] = base_q[b][e].rob_idx;
`ifdef RS_WAKEUP_BYPASS_EN
        req[b][e] = valid_q[b][e]
          & (~base_q[b][e].psrc0_valid | base_q[b][e].psrc0_ready
             | wk_hit(base_q[b][e].psrc0, bus.wakeup_valid_i, bus.wakeup_pdest_i))
          & (~base_q[b][e].psrc1_valid | base_q[b][e].psrc1_ready
             | wk_hit(base_q[b][e].psrc1, bus.wakeup_valid_i, bus.wakeup_pdest_i));
`else
        req[b][e] = valid_q[b][e]
          & (~base_q[b][e].psrc0_valid | base_q[b][e].psrc0_ready)
          & (~base_q[b][e].psrc1_valid | base_q[b][e].psrc1_ready);
`endif
      end
    end
  end

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    rs_oldest_select #(.BANK_SIZE(BANK_SIZE)) u_sel (
      .req_i      (req[b]),
      .pb_i       (pb_vec[b]),
      .rob_idx_i  (rob_vec[b]),
      .gnt_o      (gnt_oh[b]),
      .gnt_idx_o  (gnt_idx[b]),
      .gnt_valid_o(gnt_vld[b])
    );
  end

  // lowest free entry, taken from the pre-issue state so it never collides with the issued one
  always_comb begin
    free_vld = '0;
    free_idx = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int e = BANK_SIZE - 1; e >= 0; e--) begin
        if (!valid_q[b][e]) begin
          free_vld[b] = 1'b1;
          free_idx[b] = IDX_W'(e);
        end
      end
    end
  end

  always_comb begin
    bus.wr_ready_o    = free_vld;
    bus.issue_valid_o = gnt_vld;
    bus.occupancy_o   = occ_q;
    bus.issue_base_o  = '0;
    bus.issue_oc_o    = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (gnt_vld[b]) begin
        bus.issue_base_o[b].psrc0   = base_q[b][gnt_idx[b]].psrc0;
        bus.issue_base_o[b].psrc1   = base_q[b][gnt_idx[b]].psrc1;
        bus.issue_base_o[b].pdest   = base_q[b][gnt_idx[b]].pdest;
        bus.issue_base_o[b].imm     = base_q[b][gnt_idx[b]].imm;
        bus.issue_base_o[b].rob_idx = base_q[b][gnt_idx[b]].rob_idx;
        bus.issue_oc_o[b]           = oc_q[b][gnt_idx[b]];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int e = 0; e < BANK_SIZE; e++) begin
        base_d[b][e] = wk_apply(base_q[b][e], bus.wakeup_valid_i, bus.wakeup_pdest_i);
        oc_d[b][e]   = oc_q[b][e];
      end
      if (gnt_vld[b] && bus.issue_ready_i[b]) valid_d[b] = valid_d[b] & ~gnt_oh[b];
      if (bus.wr_valid_i[b] && free_vld[b]) begin
        valid_d[b][free_idx[b]] = 1'b1;
        base_d[b][free_idx[b]]  = wk_apply(bus.rs_base_i[b], bus.wakeup_valid_i, bus.wakeup_pdest_i);
        oc_d[b][free_idx[b]]    = bus.option_code_i[b];
      end
      if (flush_i) valid_d[b] = '0;
      for (int e = 0; e < BANK_SIZE; e++)
        occ_d[b] = occ_d[b] + OCC_W'(valid_d[b][e]);
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        for (int e = 0; e < BANK_SIZE; e++) begin
          base_q[b][e] <= '0;
          oc_q[b][e]   <= '0;
        end
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      base_q  <= base_d;
      oc_q    <= oc_d;
    end
  end

endmodule

// File: tb/tb_banked_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-level model.
// Follows RS_WAKEUP_BYPASS_EN when the build defines it.
module tb_banked_reservation_station;
  import banked_reservation_station_pkg::*;

  localparam int BN = 2;
  localparam int BS = 4;
  localparam int WW = 4;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  banked_reservation_station_if #(.BANK_NUM(BN), .BANK_SIZE(BS), .WAKEUP_WIDTH(WW)) bus ();

  banked_reservation_station #(.BANK_NUM(BN), .BANK_SIZE(BS), .WAKEUP_WIDTH(WW)) dut (
    .clk    (clk),
    .a_rst_n(a_rst_n),
    .flush_i(flush),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit          v;
    RsBaseSt     b;
    OptionCodeSt oc;
  } ment_t;

  ment_t mdl [BN][BS];
  int    got_rob[$];
  int    got_cyc[$];

  function automatic bit woken(input preg_t p);
    if (p == '0) return 1'b0;
    for (int k = 0; k < WW; k++)
      if (bus.wakeup_valid_i[k] && bus.wakeup_pdest_i[k] == p) return 1'b1;
    return 1'b0;
  endfunction

  // {pb, rob_idx} is a 7-bit wrapping sequence number; A is older if B lies ahead of it by less than half the ring
  function automatic bit older(input logic pa, input rob_idx_t ia, input logic pb, input rob_idx_t ib);
    int ka, kb, d;
    ka = {25'd0, pa, ia};
    kb = {25'd0, pb, ib};
    d  = (kb - ka + 128) % 128;
    return (d > 0) && (d < 64);
  endfunction

  function automatic bit opnd_ok(input logic v, input logic r, input preg_t p);
    return !v || r || (BYP && woken(p));
  endfunction

  function automatic int pick(input int b);
    int best;
    best = -1;
    for (int e = 0; e < BS; e++) begin
      if (mdl[b][e].v && opnd_ok(mdl[b][e].b.psrc0_valid, mdl[b][e].b.psrc0_ready, mdl[b][e].b.psrc0)
          && opnd_ok(mdl[b][e].b.psrc1_valid, mdl[b][e].b.psrc1_ready, mdl[b][e].b.psrc1)) begin
        if (best < 0 || older(mdl[b][e].b.position_bit, mdl[b][e].b.rob_idx,
                              mdl[b][best].b.position_bit, mdl[b][best].b.rob_idx))
          best = e;
      end
    end
    return best;
  endfunction

  function automatic RsBaseSt woken_copy(input RsBaseSt s);
    RsBaseSt r;
    r = s;
    if (s.psrc0_valid && woken(s.psrc0)) r.psrc0_ready = 1'b1;
    if (s.psrc1_valid && woken(s.psrc1)) r.psrc1_ready = 1'b1;
    return r;
  endfunction

  // compare at the falling edge, then advance the model with the inputs seen at the next rising edge
  task automatic step();
    int sel [BN];
    int cnt, fr;
    IssueBaseSt eb;
    OptionCodeSt eo;
    @(negedge clk);
    for (int b = 0; b < BN; b++) begin
      sel[b] = pick(b);
      cnt = 0;
      for (int e = 0; e < BS; e++) cnt += int'(mdl[b][e].v);
      eb = '0;
      eo = '0;
      if (sel[b] >= 0) begin
        eb.psrc0   = mdl[b][sel[b]].b.psrc0;
        eb.psrc1   = mdl[b][sel[b]].b.psrc1;
        eb.pdest   = mdl[b][sel[b]].b.pdest;
        eb.imm     = mdl[b][sel[b]].b.imm;
        eb.rob_idx = mdl[b][sel[b]].b.rob_idx;
        eo         = mdl[b][sel[b]].oc;
      end
      chk($sformatf("wr_ready[%0d]", b), 64'(bus.wr_ready_o[b]), 64'(cnt < BS));
      chk($sformatf("occupancy[%0d]", b), 64'(bus.occupancy_o[b]), 64'(cnt));
      chk($sformatf("issue_valid[%0d]", b), 64'(bus.issue_valid_o[b]), 64'(sel[b] >= 0));
      chk($sformatf("issue_base[%0d]", b), 64'(bus.issue_base_o[b]), 64'(eb));
      chk($sformatf("issue_oc[%0d]", b), 64'(bus.issue_oc_o[b]), 64'(eo));
    end
    if (bus.issue_valid_o[0] && bus.issue_ready_i[0]) begin
      got_rob.push_back(int'(bus.issue_base_o[0].rob_idx));
      got_cyc.push_back(cyc);
    end
    for (int b = 0; b < BN; b++) begin
      if (flush) begin
        for (int e = 0; e < BS; e++) mdl[b][e].v = 1'b0;
      end else begin
        fr = -1;
        for (int e = BS - 1; e >= 0; e--) if (!mdl[b][e].v) fr = e;
        for (int e = 0; e < BS; e++) if (mdl[b][e].v) mdl[b][e].b = woken_copy(mdl[b][e].b);
        if (sel[b] >= 0 && bus.issue_ready_i[b]) mdl[b][sel[b]].v = 1'b0;
        if (bus.wr_valid_i[b] && fr >= 0) begin
          mdl[b][fr].v  = 1'b1;
          mdl[b][fr].b  = woken_copy(bus.rs_base_i[b]);
          mdl[b][fr].oc = bus.option_code_i[b];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.wr_valid_i     = '0;
    bus.rs_base_i      = '0;
    bus.option_code_i  = '0;
    bus.wakeup_valid_i = '0;
    bus.wakeup_pdest_i = '0;
    bus.issue_ready_i  = '0;
    flush              = 1'b0;
  endtask

  function automatic RsBaseSt mk(input int p0, input bit v0, input bit r0, input int p1,
                                 input bit v1, input bit r1, input int rob, input bit pb);
    RsBaseSt s;
    s              = '0;
    s.psrc0        = preg_t'(p0);
    s.psrc0_valid  = v0;
    s.psrc0_ready  = r0;
    s.psrc1        = preg_t'(p1);
    s.psrc1_valid  = v1;
    s.psrc1_ready  = r1;
    s.pdest        = preg_t'($urandom);
    s.imm          = 16'($urandom);
    s.rob_idx      = rob_idx_t'(rob);
    s.position_bit = pb;
    return s;
  endfunction

  task automatic dispatch(input int b, input RsBaseSt s);
    bus.rs_base_i[b]     = s;
    bus.option_code_i[b] = OptionCodeSt'($urandom);
    bus.wr_valid_i[b]    = 1'b1;
  endtask

  task automatic chk_order(input string tag, input int exp0, input int exp1, input int exp2, input int n);
    int exp [3];
    exp = '{exp0, exp1, exp2};
    chk({tag, "_count"}, 64'(got_rob.size()), 64'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", tag, i), 64'((i < got_rob.size()) ? got_rob[i] : -1), 64'(exp[i]));
  endtask

  initial begin
    int n;
    idle();
    for (int b = 0; b < BN; b++)
      for (int e = 0; e < BS; e++) mdl[b][e].v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b1;

    // idle after reset
    repeat (10) step();
    chk("reset_wr_ready", 64'(bus.wr_ready_o), 64'(2'b11));

    // oldest-first among three resident ready entries
    got_rob.delete();
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 5, 0)); step();
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 3, 0)); step();
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 7, 0)); step();
    bus.wr_valid_i = '0;
    bus.issue_ready_i[0] = 1'b1;
    repeat (4) step();
    chk_order("age_order", 3, 5, 7, 3);

    // full bank 0 then wake a single entry
    bus.issue_ready_i[0] = 1'b1;
    dispatch(0, mk(20, 1, 0, 0, 0, 0, 10, 0)); step();
    dispatch(0, mk(21, 1, 0, 0, 0, 0, 11, 0)); step();
    dispatch(0, mk(12, 1, 0, 0, 0, 0, 12, 0)); step();
    dispatch(0, mk(22, 1, 0, 0, 0, 0, 13, 0)); step();
    bus.wr_valid_i = '0;
    chk("full_b0_wr_ready", 64'(bus.wr_ready_o[0]), 64'(0));
    chk("full_b1_wr_ready", 64'(bus.wr_ready_o[1]), 64'(1));
    got_rob.delete();
    bus.wakeup_valid_i[0] = 1'b1;
    bus.wakeup_pdest_i[0] = preg_t'(12);
    step();
    bus.wakeup_valid_i = '0;
    repeat (3) step();
    chk_order("wake12", 12, 0, 0, 1);
    chk("after_wake_wr_ready", 64'(bus.wr_ready_o[0]), 64'(1));

    // flush with three resident entries and a concurrent dispatch
    flush = 1'b1;
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 40, 0));
    step();
    idle();
    chk("flush_occ", 64'(bus.occupancy_o[0]), 64'(0));
    chk("flush_issue_valid", 64'(bus.issue_valid_o), 64'(0));
    got_rob.delete();
    bus.issue_ready_i = '1;
    repeat (3) step();
    chk("flush_no_issue", 64'(got_rob.size()), 64'(0));

    // wraparound ordering
    idle();
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 2, 1)); step();
    dispatch(0, mk(0, 0, 0, 0, 0, 0, 60, 0)); step();
    bus.wr_valid_i = '0;
    bus.issue_ready_i[0] = 1'b1;
    got_rob.delete();
    got_cyc.delete();
    repeat (3) step();
    chk_order("wrap", 60, 2, 0, 2);

    // wakeup in the dispatch cycle
    got_rob.delete();
    got_cyc.delete();
    n = cyc;
    dispatch(0, mk(9, 1, 0, 0, 0, 0, 20, 0));
    bus.wakeup_valid_i[1] = 1'b1;
    bus.wakeup_pdest_i[1] = preg_t'(9);
    step();
    bus.wr_valid_i = '0;
    bus.wakeup_valid_i = '0;
    repeat (2) step();
    chk("wk_disp_cycle", 64'((got_cyc.size() > 0) ? got_cyc[0] : -1), 64'(n + 1));

    // wakeup three cycles after dispatch
    got_rob.delete();
    got_cyc.delete();
    n = cyc;
    dispatch(0, mk(9, 1, 0, 0, 0, 0, 21, 0));
    step();
    bus.wr_valid_i = '0;
    repeat (2) step();
    bus.wakeup_valid_i[2] = 1'b1;
    bus.wakeup_pdest_i[2] = preg_t'(9);
    step();
    bus.wakeup_valid_i = '0;
    repeat (3) step();
    chk("wk_late_cycle", 64'((got_cyc.size() > 0) ? got_cyc[0] : -1), 64'(n + (BYP ? 3 : 4)));

    // random traffic on both banks
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < BN; b++) begin
        bus.wr_valid_i[b]    = ($urandom_range(99) < 60);
        bus.rs_base_i[b]     = mk($urandom_range(15), 1'($urandom), ($urandom_range(99) < 40),
                                  $urandom_range(15), 1'($urandom), ($urandom_range(99) < 40),
                                  $urandom_range(63), 1'($urandom));
        bus.option_code_i[b] = OptionCodeSt'($urandom);
        bus.issue_ready_i[b] = ($urandom_range(99) < 75);
      end
      for (int k = 0; k < WW; k++) begin
        bus.wakeup_valid_i[k] = ($urandom_range(99) < 50);
        bus.wakeup_pdest_i[k] = preg_t'($urandom_range(15));
      end
      flush = ($urandom_range(63) == 0);
      step();
    end

    idle();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
